// File: rtl/npu_agu_pkg.sv
// Shared AGU types: FSM state encoding, default widths
// and the FC tiling config bundle.
package npu_agu_pkg;

  localparam int AGU_ADDR_W   = 12;
  localparam int AGU_PIECE_W  = 8;
  localparam int AGU_STRIDE_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GRP = 2'd1,
    REQ      = 2'd2,
    DONE     = 2'd3
  } agu_state_e;

  // Config latched on an accepted start. Fields are sized
  // for the default widths; instance widths must not exceed them.
  typedef struct packed {
    logic [AGU_ADDR_W-1:0]   start_addr;
    logic [AGU_PIECE_W-1:0]  in_pieces;
    logic [AGU_PIECE_W-1:0]  out_pieces;
    logic [AGU_STRIDE_W-1:0] in_stride;
  } agu_fc_cfg_t;

endpackage

// File: rtl/agu_nested_cnt.sv
// Two-level wrap counter: inner index runs 0..innerN-1, then
// outer advances; o_wrap strobes on the advance that ends both.
// Ports: i_clk, i_rst (sync, high), i_clr, i_adv,
//   i_innerN/i_outerN (counts), o_innerLast, o_outerLast, o_wrap.
module agu_nested_cnt #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_adv,
  input  logic [W-1:0] i_innerN,
  input  logic [W-1:0] i_outerN,
  output logic         o_innerLast,
  output logic         o_outerLast,
  output logic         o_wrap
);

  logic [W-1:0] innerIdx;
  logic [W-1:0] outerIdx;

  assign o_innerLast = innerIdx == i_innerN - W'(1);
  assign o_outerLast = outerIdx == i_outerN - W'(1);
  assign o_wrap = i_adv & o_innerLast & o_outerLast;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      innerIdx <= '0;
      outerIdx <= '0;
    end else if (i_adv) begin
      if (o_innerLast) begin
        innerIdx <= '0;
        outerIdx <= o_outerLast ? '0 : outerIdx + W'(1);
      end else begin
        innerIdx <= innerIdx + W'(1);
      end
    end
  end

endmodule

// File: rtl/iagu_fc_v2.sv
// FC input address generator: per output piece, sweeps all input
// pieces at a stride, one IOB read per group trigger (valid/ready).
// Ports: i_clk, i_rst (sync, high); config i_start_addr,
//   i_in_pieces, i_out_pieces, i_in_stride; triggers i_agu_start,
//   i_group_start; IOB o_iob_ren/i_iob_rdy/o_iob_raddr/o_last_in;
//   status o_precomp_rdy, o_group_load_end, o_done, o_err_overrun.
// Option IAGU_FC_V2_PERF_EN adds o_stall_cnt (stalled req cycles).
module iagu_fc_v2
  import npu_agu_pkg::*;
#(
  parameter int ADDR_W   = AGU_ADDR_W,
  parameter int PIECE_W  = AGU_PIECE_W,
  parameter int STRIDE_W = AGU_STRIDE_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [ADDR_W-1:0]   i_start_addr,
  input  logic [PIECE_W-1:0]  i_in_pieces,
  input  logic [PIECE_W-1:0]  i_out_pieces,
  input  logic [STRIDE_W-1:0] i_in_stride,
  input  logic                i_agu_start,
  input  logic                i_group_start,
  output logic                o_precomp_rdy,
  output logic                o_iob_ren,
  input  logic                i_iob_rdy,
  output logic [ADDR_W-1:0]   o_iob_raddr,
  output logic                o_last_in,
  output logic                o_group_load_end,
  output logic                o_done,
  output logic                o_err_overrun
`ifdef IAGU_FC_V2_PERF_EN
  ,
  output logic [15:0]         o_stall_cnt
`endif
);

  agu_state_e  state;
  agu_state_e  stateNxt;
  agu_fc_cfg_t cfgQ;
  logic [ADDR_W-1:0] addrQ;
  logic errQ;

  logic startOk;
  logic zeroCfg;
  logic accept;
  logic inLast;
  logic outLast;
  logic tileEnd;
  logic dropGrp;

  assign startOk = (state == IDLE) & i_agu_start;
  assign zeroCfg = (i_in_pieces == '0) | (i_out_pieces == '0);
  assign accept  = (state == REQ) & i_iob_rdy;

  agu_nested_cnt #(
    .W(PIECE_W)
  ) uCnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (startOk),
    .i_adv      (accept),
    .i_innerN   (PIECE_W'(cfgQ.in_pieces)),
    .i_outerN   (PIECE_W'(cfgQ.out_pieces)),
    .o_innerLast(inLast),
    .o_outerLast(outLast),
    .o_wrap     (tileEnd)
  );

  // A trigger is lost while a request is still pending, when the
  // accept ends the tiling, or during the done cycle.
  assign dropGrp = i_group_start &
    (((state == REQ) & ~(accept & ~tileEnd)) |
     (state == DONE));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE: begin
        if (i_agu_start) begin
          stateNxt = zeroCfg ? DONE : WAIT_GRP;
        end
      end
      WAIT_GRP: begin
        if (i_group_start) begin
          stateNxt = REQ;
        end
      end
      REQ: begin
        if (accept) begin
          if (tileEnd) begin
            stateNxt = DONE;
          end else if (i_group_start) begin
            stateNxt = REQ;
          end else begin
            stateNxt = WAIT_GRP;
          end
        end
      end
      DONE: begin
        stateNxt = IDLE;
      end
      default: begin
        stateNxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cfgQ  <= '0;
      addrQ <= '0;
      errQ  <= 1'b0;
    end else if (startOk) begin
      cfgQ.start_addr <= AGU_ADDR_W'(i_start_addr);
      cfgQ.in_pieces  <= AGU_PIECE_W'(i_in_pieces);
      cfgQ.out_pieces <= AGU_PIECE_W'(i_out_pieces);
      cfgQ.in_stride  <= AGU_STRIDE_W'(i_in_stride);
      addrQ <= i_start_addr;
      errQ  <= 1'b0;
    end else begin
      if (accept) begin
        addrQ <= inLast ? ADDR_W'(cfgQ.start_addr)
                        : addrQ + ADDR_W'(cfgQ.in_stride);
      end
      if (dropGrp) begin
        errQ <= 1'b1;
      end
    end
  end

`ifdef IAGU_FC_V2_PERF_EN
  logic [15:0] stallQ;

  always_ff @(posedge i_clk) begin
    if (i_rst || startOk) begin
      stallQ <= '0;
    end else if ((state == REQ) && !i_iob_rdy &&
                 (stallQ != 16'hFFFF)) begin
      stallQ <= stallQ + 16'd1;
    end
  end

  assign o_stall_cnt = stallQ;
`endif

  assign o_precomp_rdy    = (state == WAIT_GRP) | (state == REQ);
  assign o_iob_ren        = state == REQ;
  assign o_iob_raddr      = (state == REQ) ? addrQ : '0;
  assign o_last_in        = (state == REQ) & inLast;
  assign o_group_load_end = accept;
  assign o_done           = state == DONE;
  assign o_err_overrun    = errQ;

endmodule

// File: tb/tb_iagu_fc_v2.sv
// Bench for iagu_fc_v2: directed scenarios with literal checks
// plus a random phase, all checked cycle-by-cycle against a model.
module tb_iagu_fc_v2;

  localparam int AW = 12;
  localparam int PW = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] startAddr = '0;
  logic [PW-1:0] inP = '0;
  logic [PW-1:0] outP = '0;
  logic [SW-1:0] stride = '0;
  logic          aguStart = 1'b0;
  logic          grpStart = 1'b0;
  logic          rdy = 1'b1;
  logic          precompRdy;
  logic          ren;
  logic [AW-1:0] raddr;
  logic          lastIn;
  logic          gle;
  logic          done;
  logic          errOvr;
`ifdef IAGU_FC_V2_PERF_EN
  logic [15:0]   stallCnt;
`endif

  int nTests = 0;
  int nFail = 0;
  bit chkEn = 1'b0;

  always #5 clk = ~clk;

  iagu_fc_v2 dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start_addr    (startAddr),
    .i_in_pieces     (inP),
    .i_out_pieces    (outP),
    .i_in_stride     (stride),
    .i_agu_start     (aguStart),
    .i_group_start   (grpStart),
    .o_precomp_rdy   (precompRdy),
    .o_iob_ren       (ren),
    .i_iob_rdy       (rdy),
    .o_iob_raddr     (raddr),
    .o_last_in       (lastIn),
    .o_group_load_end(gle),
    .o_done          (done),
    .o_err_overrun   (errOvr)
`ifdef IAGU_FC_V2_PERF_EN
    ,
    .o_stall_cnt     (stallCnt)
`endif
  );

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: the tiling is the precomputed address list; progress
  // is an index into it plus whether a request is outstanding.
  int  mSeq[$];
  int  mIdx = 0;
  int  mIn = 0;
  bit  mRun = 0;
  bit  mPend = 0;
  bit  mDoneNow = 0;
  bit  mErr = 0;
  int  mStall = 0;

  function automatic void buildSeq(int sa, int ni, int no,
                                   int st);
    mSeq.delete();
    for (int o = 0; o < no; o++)
      for (int i = 0; i < ni; i++)
        mSeq.push_back((sa + i * st) % (1 << AW));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mRun = 0; mPend = 0; mDoneNow = 0; mErr = 0;
      mIdx = 0; mIn = 0; mStall = 0;
      mSeq.delete();
    end else if (mDoneNow) begin
      if (grpStart) mErr = 1;
      mDoneNow = 0;
    end else if (!mRun) begin
      if (aguStart) begin
        mErr = 0; mStall = 0; mIdx = 0; mPend = 0;
        mIn = int'(inP);
        buildSeq(int'(startAddr), int'(inP), int'(outP),
                 int'(stride));
        if (inP == 0 || outP == 0) mDoneNow = 1;
        else mRun = 1;
      end
    end else if (mPend) begin
      if (rdy) begin
        mIdx++;
        mPend = 0;
        if (mIdx == mSeq.size()) begin
          mRun = 0;
          mDoneNow = 1;
          if (grpStart) mErr = 1;
        end else begin
          mPend = grpStart;
        end
      end else begin
        if (mStall < 16'hFFFF) mStall++;
        if (grpStart) mErr = 1;
      end
    end else if (grpStart) begin
      mPend = 1;
    end
  end

  // Per-cycle compare plus captures for the literal checks.
  int capQ[$];
  int acceptCyc[$];
  int doneCnt = 0;
  int renCnt = 0;
  int lastCnt = 0;
  int preCnt = 0;
  int stallHits = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (chkEn) begin
      chk("ren", 32'(ren), 32'(mPend));
      chk("raddr", 32'(raddr),
          mPend ? 32'(mSeq[mIdx]) : 32'd0);
      chk("last_in", 32'(lastIn),
          32'(mPend && (mIdx % mIn == mIn - 1)));
      chk("gle", 32'(gle), 32'(mPend && rdy));
      chk("done", 32'(done), 32'(mDoneNow));
      chk("precomp", 32'(precompRdy), 32'(mRun));
      chk("err", 32'(errOvr), 32'(mErr));
`ifdef IAGU_FC_V2_PERF_EN
      chk("stall_cnt", 32'(stallCnt), 32'(mStall));
`endif
    end
    if (gle) begin
      capQ.push_back(int'(raddr));
      acceptCyc.push_back(cyc);
    end
    if (done) doneCnt++;
    if (ren) renCnt++;
    if (lastIn) lastCnt++;
    if (precompRdy) preCnt++;
    if (ren && !rdy && raddr == 12'h101) stallHits++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearCap();
    capQ.delete();
    acceptCyc.delete();
    lastCnt = 0;
    stallHits = 0;
  endtask

  task automatic startT(int sa, int ni, int no, int st);
    startAddr = AW'(sa);
    inP = PW'(ni);
    outP = PW'(no);
    stride = SW'(st);
    aguStart = 1'b1;
    tick();
    aguStart = 1'b0;
  endtask

  task automatic finishTiling(int maxCyc);
    int d0;
    bit ok;
    d0 = doneCnt;
    ok = 0;
    rdy = 1'b1;
    for (int i = 0; i < maxCyc; i++) begin
      if (doneCnt > d0) begin
        ok = 1;
        break;
      end
      grpStart = (i % 2 == 0);
      tick();
    end
    grpStart = 1'b0;
    if (!ok) begin
      nTests++;
      nFail++;
      $display("FAIL timeout: no done after %0d cycles", maxCyc);
    end
  endtask

  task automatic chkSeq(string nm, int exp[$]);
    chk({nm, "_n"}, 32'(capQ.size()), 32'(exp.size()));
    foreach (exp[i])
      chk(nm, (i < capQ.size()) ? 32'(capQ[i]) : 32'hDEAD,
          32'(exp[i]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int r0;
    int p0;
    int k;
    int sweepExp[$];
    int wrapExp[$];

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chkEn = 1'b1;

    // Reset state.
    chk("rst_ren", 32'(ren), 0);
    chk("rst_raddr", 32'(raddr), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pre", 32'(precompRdy), 0);
    chk("rst_err", 32'(errOvr), 0);

    // Basic sweep.
    clearCap();
    d0 = doneCnt;
    startT(12'h100, 3, 2, 1);
    rdy = 1'b1;
    repeat (6) begin
      grpStart = 1'b1;
      tick();
      grpStart = 1'b0;
      repeat (3) tick();
    end
    repeat (3) tick();
    sweepExp = '{'h100, 'h101, 'h102, 'h100, 'h101, 'h102};
    chkSeq("sweep_addr", sweepExp);
    chk("sweep_last", 32'(lastCnt), 2);
    chk("sweep_done", 32'(doneCnt - d0), 1);

    // Back-pressure on the second request.
    clearCap();
    startT(12'h100, 3, 2, 1);
    rdy = 1'b1;
    grpStart = 1'b1;
    tick();
    grpStart = 1'b0;
    repeat (2) tick();
    rdy = 1'b0;
    grpStart = 1'b1;
    tick();
    grpStart = 1'b0;
    repeat (5) tick();
    rdy = 1'b1;
    tick();
    chk("bp_hold", 32'(stallHits), 5);
    chk("bp_pulses", 32'(capQ.size()), 2);
    finishTiling(100);
`ifdef IAGU_FC_V2_PERF_EN
    chk("bp_stall_lit", 32'(stallCnt), 5);
`endif

    // Stride with address wrap.
    clearCap();
    startT(12'hFFE, 3, 1, 2);
    finishTiling(100);
    wrapExp = '{'hFFE, 'h000, 'h002};
    chkSeq("wrap_addr", wrapExp);
    chkSeq("wrap_model", mSeq);

    // Zero config.
    repeat (2) tick();
    d0 = doneCnt;
    r0 = renCnt;
    p0 = preCnt;
    startT(12'h010, 0, 5, 1);
    repeat (3) tick();
    chk("zero_done", 32'(doneCnt - d0), 1);
    chk("zero_ren", 32'(renCnt - r0), 0);
    chk("zero_pre", 32'(preCnt - p0), 0);

    // Back-to-back: trigger held high.
    clearCap();
    d0 = doneCnt;
    startT(12'h200, 4, 2, 1);
    rdy = 1'b1;
    grpStart = 1'b1;
    for (int i = 0; i < 40 && doneCnt == d0; i++) tick();
    grpStart = 1'b0;
    tick();
    chk("b2b_n", 32'(capQ.size()), 8);
    if (acceptCyc.size() == 8)
      chk("b2b_span", 32'(acceptCyc[7] - acceptCyc[0]), 7);
    else
      chk("b2b_span", 32'(acceptCyc.size()), 8);

    // Overrun while stalled; sticky until next start.
    tick();
    startT(12'h300, 2, 1, 1);
    rdy = 1'b0;
    grpStart = 1'b1;
    tick();
    grpStart = 1'b0;
    tick();
    grpStart = 1'b1;
    tick();
    grpStart = 1'b0;
    tick();
    chk("ovr_set", 32'(errOvr), 1);
    finishTiling(100);
    tick();
    chk("ovr_sticky", 32'(errOvr), 1);
    startT(12'h300, 2, 1, 1);
    chk("ovr_clr", 32'(errOvr), 0);
    finishTiling(100);

    // Reset mid-run, then replay.
    tick();
    clearCap();
    startT(12'h100, 3, 2, 1);
    rdy = 1'b1;
    for (int i = 0; i < 40 && capQ.size() < 2; i++) begin
      grpStart = (i % 2 == 0);
      tick();
    end
    grpStart = 1'b0;
    d0 = doneCnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_ren", 32'(ren), 0);
    chk("mrst_pre", 32'(precompRdy), 0);
    chk("mrst_raddr", 32'(raddr), 0);
    repeat (3) tick();
    chk("mrst_nodone", 32'(doneCnt - d0), 0);
    clearCap();
    startT(12'h100, 3, 2, 1);
    finishTiling(100);
    chkSeq("replay_addr", sweepExp);

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      k = int'($urandom_range(0, 999));
      rst = (k < 2);
      aguStart = ($urandom_range(0, 19) == 0);
      startAddr = AW'($urandom);
      inP = PW'($urandom_range(0, 4));
      outP = PW'($urandom_range(0, 3));
      stride = SW'($urandom);
      grpStart = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0;
    aguStart = 1'b0;
    grpStart = 1'b0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
